// File: rtl/inst_fetch_queue.sv
// In-order instruction queue between fetch and decode: valid/ready on both sides,
// wrong-path discard on Flush, and fetch blocking once a HALT has been captured.
module inst_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_W     = 2,
  parameter int unsigned CNT_W     = 3,
  parameter logic [8:0]  HALT_INST = 9'b111111111
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic             InValid,
  input  logic [10:0]      InPC,
  input  logic [8:0]       InInst,
  output logic             InReady,
  output logic             OutValid,
  output logic [10:0]      OutPC,
  output logic [8:0]       OutInst,
  input  logic             OutReady,
  output logic             Halted,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [10:0]      pc_mem   [DEPTH];
  logic [8:0]       inst_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             clear;
  logic             enq;
  logic             deq;
  logic             is_empty;

  assign clear    = Start | Flush;
  assign is_empty = (Count == '0);

  // Start/Flush gate both handshakes so nothing moves in a clearing cycle.
  assign InReady  = (Count != FULL_CNT) & ~Halted & ~clear;
  assign OutValid = ~is_empty & ~clear;
  assign enq      = InValid & InReady;
  assign deq      = OutValid & OutReady;

  assign OutPC    = is_empty ? 11'd0 : pc_mem[rd_ptr];
  assign OutInst  = is_empty ? HALT_INST : inst_mem[rd_ptr];

  // Storage is data only; its contents are meaningless while Count is 0.
  always_ff @(posedge Clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= InPC;
      inst_mem[wr_ptr] <= InInst;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Halted <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Halted <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
      if (enq && (InInst == HALT_INST)) Halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: stimulus pushes expected pairs into a scoreboard
// queue, an independent monitor pops and compares whenever decode consumes an entry.
module tb_inst_fetch_queue;

  localparam logic [8:0] HALT = 9'b111111111;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic [10:0] InPC = '0;
  logic [8:0]  InInst = '0;
  logic        InReady;
  logic        OutValid;
  logic [10:0] OutPC;
  logic [8:0]  OutInst;
  logic        OutReady = 1'b0;
  logic        Halted;
  logic [2:0]  Count;

  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q [$];

  inst_fetch_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(3), .HALT_INST(HALT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Flush(Flush),
    .InValid(InValid), .InPC(InPC), .InInst(InInst), .InReady(InReady),
    .OutValid(OutValid), .OutPC(OutPC), .OutInst(OutInst), .OutReady(OutReady),
    .Halted(Halted), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed head entry must be the oldest outstanding expected pair.
  always @(negedge Clk) begin
    if (!Reset && OutValid === 1'b1 && OutReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc=%0d inst=%b expected nothing", OutPC, OutInst);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("out_pc", 32'(OutPC), 32'(e[19:9]));
        check("out_inst", 32'(OutInst), 32'(e[8:0]));
      end
    end
  end

  // Drive one cycle's inputs, then at the falling edge confirm InReady and record acceptance.
  task automatic cyc(input logic iv, input logic [10:0] pc, input logic [8:0] ins,
                     input logic ordy, input logic exp_rdy);
    InValid  = iv;
    InPC     = pc;
    InInst   = ins;
    OutReady = ordy;
    @(negedge Clk);
    check("in_ready", 32'(InReady), 32'(exp_rdy));
    if (iv && exp_rdy) exp_q.push_back({pc, ins});
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_out_valid", 32'(OutValid), 32'd0);
    check("rst_in_ready", 32'(InReady), 32'd1);
    check("rst_out_pc", 32'(OutPC), 32'd0);
    check("rst_out_inst", 32'(OutInst), 32'(HALT));
    check("rst_count", 32'(Count), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    tick;
    Reset = 1'b0;
    tick;

    // Fill to full with decode stalled, then drain in order.
    cyc(1'b1, 11'd0, 9'b000110001, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd1, 9'b100000010, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd2, 9'b000110011, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd3, 9'b010011001, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd9, 9'b000000001, 1'b1, 1'b0);
    check("full_count", 32'(Count), 32'd4);
    tick;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 11'd0, 9'd0, 1'b1, 1'b1); tick;
    end
    cyc(1'b0, 11'd0, 9'd0, 1'b0, 1'b1);
    check("drained_count", 32'(Count), 32'd0);
    check("drained_valid", 32'(OutValid), 32'd0);
    tick;

    // Empty queue: one cycle from accept to present, no bypass.
    cyc(1'b1, 11'd5, 9'b000110001, 1'b0, 1'b1);
    check("nobypass_valid", 32'(OutValid), 32'd0);
    tick;
    cyc(1'b0, 11'd0, 9'd0, 1'b0, 1'b1);
    check("lat1_valid", 32'(OutValid), 32'd1);
    check("lat1_pc", 32'(OutPC), 32'd5);
    tick;
    cyc(1'b0, 11'd0, 9'd0, 1'b1, 1'b1); tick;

    // Steady streaming at Count=2: pointers wrap several times.
    cyc(1'b1, 11'd30, 9'b000000011, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd31, 9'b000000111, 1'b0, 1'b1); tick;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 11'(40 + i), 9'(i * 37), 1'b1, 1'b1);
      check("stream_count", 32'(Count), 32'd2);
      tick;
    end
    cyc(1'b0, 11'd0, 9'd0, 1'b1, 1'b1); tick;
    cyc(1'b0, 11'd0, 9'd0, 1'b1, 1'b1); tick;
    cyc(1'b0, 11'd0, 9'd0, 1'b0, 1'b1);
    check("stream_end_count", 32'(Count), 32'd0);
    tick;

    // Flush at Count=3 with both handshakes requested.
    cyc(1'b1, 11'd60, 9'b001000001, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd61, 9'b001000010, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd62, 9'b001000011, 1'b0, 1'b1); tick;
    Flush = 1'b1;
    cyc(1'b1, 11'd63, 9'b001000100, 1'b1, 1'b0);
    check("flush_out_valid", 32'(OutValid), 32'd0);
    tick;
    exp_q.delete();
    Flush = 1'b0;
    cyc(1'b0, 11'd0, 9'd0, 1'b0, 1'b1);
    check("post_flush_count", 32'(Count), 32'd0);
    check("post_flush_valid", 32'(OutValid), 32'd0);
    tick;

    // HALT blocks fetch but still drains; Start releases it.
    cyc(1'b1, 11'd7, HALT, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd8, 9'b000000101, 1'b1, 1'b0);
    check("halted_set", 32'(Halted), 32'd1);
    tick;
    cyc(1'b1, 11'd8, 9'b000000101, 1'b0, 1'b0);
    check("halted_drained_count", 32'(Count), 32'd0);
    check("halted_hold", 32'(Halted), 32'd1);
    tick;
    Start = 1'b1;
    cyc(1'b1, 11'd9, 9'b000000110, 1'b0, 1'b0);
    tick;
    Start = 1'b0;
    cyc(1'b0, 11'd0, 9'd0, 1'b0, 1'b1);
    check("start_clears_halt", 32'(Halted), 32'd0);
    tick;

    // Asynchronous reset mid-cycle with Count=3 and Halted set.
    cyc(1'b1, 11'd20, 9'b000001000, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd21, 9'b000001001, 1'b0, 1'b1); tick;
    cyc(1'b1, 11'd22, HALT, 1'b0, 1'b1); tick;
    InValid = 1'b0;
    check("pre_reset_count", 32'(Count), 32'd3);
    check("pre_reset_halted", 32'(Halted), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    check("async_rst_count", 32'(Count), 32'd0);
    check("async_rst_valid", 32'(OutValid), 32'd0);
    check("async_rst_halted", 32'(Halted), 32'd0);
    check("async_rst_in_ready", 32'(InReady), 32'd1);
    exp_q.delete();
    tick;
    Reset = 1'b0;
    tick;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Small in-order instruction queue between the instruction fetch/ROM stage and decode.
- Captures each fetched {program counter, 9-bit instruction} pair and presents it to decode with a valid/ready handshake.
- Absorbs decode stalls, discards wrong-path entries on a taken branch, and stops accepting fetches once a HALT instruction is captured, until the next Start.

Parameters:
- DEPTH, 4, number of entries; power of 2, at least 2.
- PTR_W, 2, log2(DEPTH); read/write pointer width.
- CNT_W, 3, log2(DEPTH)+1; occupancy counter width.
- HALT_INST, 9'b111111111, instruction encoding that halts fetch.

Ports:
- Clk  input  1  clock; posedge is the only active edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  new-program pulse; empties the queue and clears Halted.
- Flush  input  1  taken branch; discards every queued entry.
- InValid  input  1  fetch stage presents a pair this cycle.
- InPC  input  11  program counter of the presented instruction.
- InInst  input  9  presented instruction word.
- InReady  output  1  queue accepts the presented pair this cycle.
- OutValid  output  1  head entry is available to decode.
- OutPC  output  11  program counter of the head entry.
- OutInst  output  9  instruction word of the head entry.
- OutReady  input  1  decode consumes the head entry this cycle.
- Halted  output  1  a HALT has been captured; fetch is blocked.
- Count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, any time):
  - Both pointers and Count go to 0; Halted=0.
  - Storage contents are don't-care.
  - Outputs during and after reset: OutValid=0, InReady=1, OutPC=0, OutInst=HALT_INST.
- Definitions:
  - enq = InValid & InReady.
  - deq = OutValid & OutReady.
- Combinational outputs:
  - InReady = (Count != DEPTH) & ~Halted & ~Start & ~Flush.
  - OutValid = (Count != 0) & ~Start & ~Flush.
  - OutPC/OutInst = head entry when Count != 0; otherwise 0 / HALT_INST.
- Enqueue on posedge with enq:
  - Write {InPC, InInst} at the write pointer.
  - Write pointer increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Dequeue on posedge with deq:
  - Read pointer increments modulo DEPTH.
- Count update:
  - enq only: Count+1.
  - deq only: Count-1.
  - Both: unchanged.
  - Neither: unchanged.
- Latency:
  - No bypass: an entry enqueued at edge N is first visible on OutValid/OutPC/OutInst after edge N.
  - When the queue is empty, accept-to-present latency is exactly 1 cycle.
- Full (Count == DEPTH):
  - InReady=0 even if deq occurs in the same cycle; no enqueue-while-full.
  - The freed slot is usable from the next cycle.
- Empty (Count == 0):
  - OutValid=0; OutReady is ignored.
- Halt:
  - An accepted pair with InInst == HALT_INST is enqueued normally.
  - Halted=1 from the following cycle, which forces InReady=0.
  - Queued entries, including the HALT, continue to drain to decode.
- Flush:
  - At the posedge, both pointers and Count go to 0 and Halted goes to 0, since the HALT was wrong-path.
  - No enqueue or dequeue occurs in a Flush cycle; both are forced off combinationally.
- Start:
  - Same clearing effect as Flush.
  - Start outranks Flush; Reset outranks both.
- A Start or Flush asserted for several consecutive cycles holds the queue empty and blocked for those cycles.
- Normal operation resumes on the first cycle both are low.
- Count never exceeds DEPTH and never underflows.
- No X may propagate to InReady, OutValid, Halted or Count after reset.

Test Plan:
- Reset, then in consecutive cycles present PC 0/'b000110001, PC 1/'b100000010, PC 2/'b000110011, PC 3/'b010011001 with OutReady=0 -> Count reaches 4, InReady=0. Then set OutReady=1 -> the four entries emerge in order with matching PCs, and Count returns to 0.
- Empty queue: enqueue PC 5/'b000110001 -> OutValid=0 in the accept cycle, OutValid=1 with OutPC=5 one cycle later.
- Count=2 with InValid=1 and OutReady=1 held for 10 cycles -> Count stays 2, output order equals input order, and pointers wrap at least twice without loss.
- Count=3, assert Flush with InValid=1 and OutReady=1 -> no handshake that cycle; next cycle Count=0, OutValid=0, InReady=1.
- Enqueue PC 7/HALT_INST followed by InValid held high -> Halted=1 and InReady=0 from the next cycle; the HALT is still dequeued. A Start pulse then clears Halted, and InReady=1.
- Assert Reset asynchronously mid-cycle with Count=3 -> Count=0, OutValid=0, Halted=0 immediately, without waiting for a clock edge.
